// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle MIPS datapath.
// Holds the PC, requests the instruction word from instruction memory,
// presents it to the decoder for one EXEC cycle (longer while stalled) and
// then updates the PC from pc_op / alu_zero / is_jr.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pc_op, is_jr, jr_addr next-PC select, jr override and jr target
//   alu_zero, stall       ALU zero flag, EXEC hold
//   imem_req/addr/ack/rdata  instruction memory handshake
//   instr, instr_valid, opcode  latched instruction and decoder opcode
//   pc, pc_plus4          current instruction address and link value
//   fetch_err, misaligned one-cycle event pulses
//   dbg_state             current FSM state (0 FETCH, 1 EXEC, 2 RETRY)
//
// Handshake: imem_req is high for every cycle spent in FETCH with
// imem_addr = pc; a transfer happens in the cycle where imem_req and
// imem_ack are both high, and imem_rdata is captured in that same cycle.
// imem_ack while imem_req is low is ignored.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_op,
  input  logic        is_jr,
  input  logic [31:0] jr_addr,
  input  logic        alu_zero,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_RETRY = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        misaligned_q, misaligned_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] seq_pc, btgt, jtgt, next_pc;

  // Next-PC candidates, all modulo 2^32.
  assign seq_pc = pc_q + 32'd4;
  assign btgt   = seq_pc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jtgt   = {seq_pc[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    if (is_jr) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else begin
      case (pc_op)
        2'b00:   next_pc = seq_pc;
        2'b01:   next_pc = alu_zero ? btgt : seq_pc;
        2'b10:   next_pc = jtgt;
        default: next_pc = alu_zero ? seq_pc : btgt;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    cnt_d         = cnt_q;
    fetch_err_d   = 1'b0;
    misaligned_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          cnt_d         = 8'd0;
          state_d       = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          fetch_err_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_RETRY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RETRY: begin
        // One idle cycle so memory sees the request drop before re-issue.
        cnt_d   = 8'd0;
        state_d = S_FETCH;
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          misaligned_d  = is_jr && (jr_addr[1:0] != 2'b00);
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      cnt_q         <= 8'd0;
      fetch_err_q   <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      cnt_q         <= cnt_d;
      fetch_err_q   <= fetch_err_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Request is gated by rst_n so an ack arriving while reset is held can
  // never look like a completed transfer.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_valid_q ? instr_q[31:26] : 6'b111111;
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign fetch_err   = fetch_err_q;
  assign misaligned  = misaligned_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int          ACK_TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  pc_op = 2'b00;
  logic        is_jr = 1'b0;
  logic [31:0] jr_addr = 32'd0;
  logic        alu_zero = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic        misaligned;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_op(pc_op), .is_jr(is_jr), .jr_addr(jr_addr),
    .alu_zero(alu_zero), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_err(fetch_err), .misaligned(misaligned), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_err = 0;
  logic [31:0] model_pc;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC computed from the architectural rules with plain
  // integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] op, input logic jr,
                                           input logic [31:0] jra, input logic z);
    longint seq, br, jt;
    bit taken;
    seq = (longint'(p) + 4) % 64'h1_0000_0000;
    br  = (seq + longint'($signed(w[15:0])) * 4 + 64'h1_0000_0000) % 64'h1_0000_0000;
    jt  = (seq / 64'h1000_0000) * 64'h1000_0000 + longint'(w[25:0]) * 4;
    if (jr) return (jra / 4) * 4;
    case (op)
      2'b00:   taken = 1'b0;
      2'b01:   taken = z;
      2'b10:   return jt[31:0];
      default: taken = !z;
    endcase
    return taken ? br[31:0] : seq[31:0];
  endfunction

  // driver: one complete fetch + execute of a single instruction
  task automatic fetch_exec(input logic [31:0] word, input int delay, input logic [1:0] op,
                            input logic jr, input logic [31:0] jra, input logic z,
                            input int stall_n);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, model_pc);
    check("idle_opcode", {26'd0, opcode}, 32'h3F);
    check("idle_valid", {31'd0, instr_valid}, 32'd0);
    for (int d = 0; d < delay; d++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    stall = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_instr", instr, word);
    check("exec_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("exec_req", {31'd0, imem_req}, 32'd0);
    check("exec_pc", pc, model_pc);
    check("exec_mis_clear", {31'd0, misaligned}, 32'd0);
    pc_op = op;
    is_jr = jr;
    jr_addr = jra;
    for (int s = 0; s < stall_n; s++) begin
      stall = 1'b1;
      alu_zero = (s == 0) ? !z : 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("held_instr", instr, word);
      check("held_pc", pc, model_pc);
      check("held_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
      check("held_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    alu_zero = z;
    imem_ack = 1'b0;
    @(negedge clk);
    exp = ref_next(model_pc, word, op, jr, jra, z);
    exp_q.push_back(exp);
    model_pc = exp;
    check("next_pc", pc, exp_q.pop_front());
    check("mis_pulse", {31'd0, misaligned}, {31'd0, jr && (jra[1:0] != 2'b00)});
    check("after_valid", {31'd0, instr_valid}, 32'd0);
    is_jr = 1'b0;
    pc_op = 2'b00;
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [1:0]  op;
    logic        jr;
    logic [31:0] jra;
    logic        z;
    int          stall_n;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h1022_FFFE, 2'b01, 1'b0, 32'h0, 1'b1, 0, 32'h0000_00FC, 1'b0};
    vecs[1] = '{32'h0000_0100, 32'h1022_FFFE, 2'b01, 1'b0, 32'h0, 1'b0, 0, 32'h0000_0104, 1'b0};
    vecs[2] = '{32'h0000_0100, 32'h1422_FFFE, 2'b11, 1'b0, 32'h0, 1'b1, 0, 32'h0000_0104, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'h1422_FFFE, 2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0000_00FC, 1'b0};
    vecs[4] = '{32'h1000_0008, 32'h0800_0010, 2'b10, 1'b0, 32'h0, 1'b0, 0, 32'h1000_0040, 1'b0};
    vecs[5] = '{32'h1000_0008, 32'h0800_0010, 2'b10, 1'b1, 32'h0000_2003, 1'b0, 0, 32'h0000_2000, 1'b1};
    vecs[6] = '{32'h0000_0100, 32'h1022_FFFE, 2'b01, 1'b0, 32'h0, 1'b1, 3, 32'h0000_00FC, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0020, 2'b00, 1'b0, 32'h0, 1'b0, 0, 32'h0000_0000, 1'b0};

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'h3F);
    check("rst_err", {30'd0, fetch_err, misaligned}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    model_pc = RST_PC;

    // sequential run from reset: 0x40, 0x44, 0x48
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_addr, RST_PC + 32'(i * 4));
      fetch_exec(32'h0000_0020 + 32'(i), 0, 2'b00, 1'b0, 32'd0, 1'b0, 0);
    end

    // table of directed next-PC cases
    for (int i = 0; i < 8; i++) begin
      fetch_exec(32'h0000_0008, 0, 2'b00, 1'b1, vecs[i].start_pc, 1'b0, 0);
      fetch_exec(vecs[i].word, 0, vecs[i].op, vecs[i].jr, vecs[i].jra, vecs[i].z, vecs[i].stall_n);
      check("vec_pc", pc, vecs[i].exp_pc);
      check("vec_mis", {31'd0, misaligned}, {31'd0, vecs[i].exp_mis});
    end

    // ack timeout, retry, then successful fetch at the same address
    for (int i = 0; i < ACK_TO; i++) begin
      check("to_req", {31'd0, imem_req}, 32'd1);
      check("to_noerr", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
    end
    check("retry_req", {31'd0, imem_req}, 32'd0);
    check("fetch_err_pulse", {31'd0, fetch_err}, 32'd1);
    @(negedge clk);
    check("refetch_req", {31'd0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, model_pc);
    check("err_one_cycle", {31'd0, fetch_err}, 32'd0);
    fetch_exec(32'h0000_0020, 0, 2'b00, 1'b0, 32'd0, 1'b0, 0);

    // reset mid-FETCH with an ack arriving while reset is held
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pc", pc, RST_PC);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_ack_req", {31'd0, imem_req}, 32'd0);
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("late_ack_instr", instr, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    model_pc = RST_PC;
    @(negedge clk);
    check("restart_addr", imem_addr, RST_PC);

    // randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      logic j;
      w = $urandom;
      j = ($urandom_range(0, 7) == 0);
      fetch_exec(w, $urandom_range(0, 3), 2'($urandom_range(0, 3)), j, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
